logic_unit_pipe: RTL

Parametrised, pipelined bitwise logic unit. It is the multi-bit, multi-op, registered successor of the single-bit 2-input gate.
- Computes AND / OR / XOR / ANDN on two WIDTH-bit operands.
- Result passes through STAGES register stages with valid/ready flow control.
- Feeds the execute stage's logical-op path (and/or/xor/andi/ori/xori) in the core.

---
 rtl/logic_unit_pipe.sv | 130 +++++++++++++
 1 files changed

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: AND/OR/XOR/ANDN with STAGES registers and valid/ready flow.
// Optional output-transfer counter enabled by defining LOGIC_UNIT_PIPE_OPCNT_EN.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
`ifdef LOGIC_UNIT_PIPE_OPCNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_ANDN = 2'b11
  } op_e;

  logic [WIDTH-1:0] result;
  logic             result_zero;
  logic             accept;
  logic [STAGES:0]  adv_chain;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] zero_q, zero_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];

  always_comb begin
    result = '0;
    case (op_e'(in_op))
      OP_AND:  result = in_a & in_b;
      OP_OR:   result = in_a | in_b;
      OP_XOR:  result = in_a ^ in_b;
      OP_ANDN: result = in_a & ~in_b;
      default: result = '0;
    endcase
    result_zero = (result == '0);
  end

  // A stage may load when it is empty or the stage after it is moving;
  // the chain runs back from out_ready so a draining full pipe still accepts.
  always_comb begin
    adv_chain         = '0;
    adv_chain[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv_chain[i] = !valid_q[i] || adv_chain[i+1];
    end
  end

  assign in_ready = adv_chain[0];
  assign accept   = in_valid && adv_chain[0];

  // Data only changes when a valid beat is loaded, so an emptied stage keeps its last value.
  always_comb begin
    valid_d = valid_q;
    zero_d  = zero_q;
    data_d  = data_q;
    if (adv_chain[0]) begin
      valid_d[0] = accept;
      if (accept) begin
        data_d[0] = result;
        zero_d[0] = result_zero;
      end
    end
    for (int i = 1; i < STAGES; i++) begin
      if (adv_chain[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
          zero_d[i] = zero_q[i-1];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
          zero_q[gi]  <= 1'b0;
          data_q[gi]  <= '0;
        end else begin
          valid_q[gi] <= valid_d[gi];
          zero_q[gi]  <= zero_d[gi];
          data_q[gi]  <= data_d[gi];
        end
      end
    end
  endgenerate

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_zero  = zero_q[STAGES-1];

`ifdef LOGIC_UNIT_PIPE_OPCNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (out_valid && out_ready) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= 16'd0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule
